dw_window_feeder: RTL and testbench

Produces the zero-padded 3×3, 4-channel windows that the depthwise convolution engine consumes. It reads an input feature map from an on-chip buffer holding one pixel of four channels per word. It walks spatial positions row-major and channel groups innermost, and presents one window set per valid/ready handshake with `channel_sel` aligned to the data. It sits between the intermediate feature buffer and the depthwise unit, as the producer end of the window interface.

---
 rtl/dw_feeder_pkg.sv | 25 ++
 rtl/dw_window_feeder_if.sv | 31 +++
 rtl/dw_tap_addr_gen.sv | 36 +++
 rtl/dw_window_feeder.sv | 171 +++++++++++++++++
 tb/tb_dw_window_feeder.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dw_feeder_pkg.sv
// dw_feeder_pkg: shared types and constants for the
// depthwise window feeder.
package dw_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LAND,
    OUT,
    FIN
  } feed_state_e;

  localparam int TAP_COUNT = 9;
  localparam int PAD       = 1;
  localparam int LANES     = 4;

  function automatic logic [7:0] ceil_groups(
    input logic [7:0] c
  );
    logic [8:0] s;
    s = {1'b0, c} + 9'(LANES - 1);
    return 8'(s / 9'(LANES));
  endfunction

endpackage

// File: rtl/dw_window_feeder_if.sv
// dw_window_feeder_if: window set handshake between
// the feeder (master) and the depthwise unit (slave).
interface dw_window_feeder_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH*9-1:0] window_feature1;
  logic [DATA_WIDTH*9-1:0] window_feature2;
  logic [DATA_WIDTH*9-1:0] window_feature3;
  logic [DATA_WIDTH*9-1:0] window_feature4;
  logic                    win_valid;
  logic                    win_ready;
  logic [7:0]              channel_sel;
  logic                    win_last_group;
  logic                    win_last;

  modport master (
    output window_feature1, window_feature2,
    output window_feature3, window_feature4,
    output win_valid, channel_sel,
    output win_last_group, win_last,
    input  win_ready
  );

  modport slave (
    input  window_feature1, window_feature2,
    input  window_feature3, window_feature4,
    input  win_valid, channel_sel,
    input  win_last_group, win_last,
    output win_ready
  );
endinterface

// File: rtl/dw_tap_addr_gen.sv
// dw_tap_addr_gen: maps an output pixel, kernel tap and
// channel group to a buffer word address plus in-range flag.
module dw_tap_addr_gen
  import dw_feeder_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [7:0]            h,
  input  logic [7:0]            w,
  input  logic [1:0]            ky,
  input  logic [1:0]            kx,
  input  logic [7:0]            g,
  input  logic [7:0]            size,
  input  logic [7:0]            groups,
  output logic                  in_range,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [9:0]  yp, xp, y, x;
  logic [31:0] lin;

  // yp/xp carry the +PAD offset so padding never goes negative
  always_comb begin
    yp = {2'b00, h} + {8'b0, ky};
    xp = {2'b00, w} + {8'b0, kx};
    y  = yp - 10'(PAD);
    x  = xp - 10'(PAD);
    in_range = (yp >= 10'(PAD)) && (xp >= 10'(PAD))
            && (y < {2'b00, size})
            && (x < {2'b00, size});
    lin = (32'(y) * 32'(size) + 32'(x))
        * 32'(groups) + 32'(g);
    addr = in_range ? ADDR_WIDTH'(lin) : '0;
  end

endmodule

// File: rtl/dw_window_feeder.sv
// dw_window_feeder: walks the feature map row-major with
// channel groups innermost and presents padded 3x3 windows.
module dw_window_feeder
  import dw_feeder_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int KERNEL_SIZE         = 3,
  parameter int CHANNEL_PARALLELISM = 4,
  parameter int ADDR_WIDTH          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            input_size,
  input  logic [7:0]            channel,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH*CHANNEL_PARALLELISM-1:0] rd_data,
  dw_window_feeder_if.master    win,
  output logic                  busy,
  output logic                  done
);

  feed_state_e state_q, state_d;
  logic [3:0] t_q, t_d;
  logic [7:0] h_q, h_d, w_q, w_d, g_q, g_d;
  logic [7:0] size_q, size_d;
  logic [7:0] chan_q, chan_d;
  logic [7:0] grp_q, grp_d;

  logic       pend_q, rng_q;
  logic [3:0] tap_p_q;
  logic [CHANNEL_PARALLELISM-1:0][TAP_COUNT-1:0]
        [DATA_WIDTH-1:0] win_q;

  logic [CHANNEL_PARALLELISM-1:0] lane_on;
  logic                  tap_rng;
  logic [ADDR_WIDTH-1:0] tap_addr;
  logic                  last_g, last_w, last_h;
  logic                  out_st;

  dw_tap_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr (
    .h       (h_q),
    .w       (w_q),
    .ky      (2'(t_q / 4'(KERNEL_SIZE))),
    .kx      (2'(t_q % 4'(KERNEL_SIZE))),
    .g       (g_q),
    .size    (size_q),
    .groups  (grp_q),
    .in_range(tap_rng),
    .addr    (tap_addr)
  );

  assign last_g = g_q == grp_q - 8'd1;
  assign last_w = w_q == size_q - 8'd1;
  assign last_h = h_q == size_q - 8'd1;

  // lanes past the channel count read as zero
  always_comb begin
    lane_on = '0;
    for (int l = 0; l < CHANNEL_PARALLELISM; l++)
      lane_on[l] = (10'({g_q, 2'b00}) + 10'(l))
                 < {2'b00, chan_q};
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    h_d     = h_q;
    w_d     = w_q;
    g_d     = g_q;
    size_d  = size_q;
    chan_d  = chan_q;
    grp_d   = grp_q;
    unique case (state_q)
      IDLE: if (start) begin
        size_d = input_size;
        chan_d = channel;
        grp_d  = ceil_groups(channel);
        t_d    = '0;
        h_d    = '0;
        w_d    = '0;
        g_d    = '0;
        if (input_size == 8'd0 || channel == 8'd0)
          state_d = FIN;
        else
          state_d = FETCH;
      end
      FETCH: begin
        if (t_q == 4'(TAP_COUNT - 1)) begin
          t_d     = '0;
          state_d = LAND;
        end else begin
          t_d = t_q + 4'd1;
        end
      end
      LAND: state_d = OUT;
      OUT: if (win.win_ready) begin
        state_d = FETCH;
        if (!last_g) begin
          g_d = g_q + 8'd1;
        end else begin
          g_d = '0;
          if (!last_w) begin
            w_d = w_q + 8'd1;
          end else begin
            w_d = '0;
            if (!last_h) h_d = h_q + 8'd1;
            else state_d = FIN;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tap data lands one cycle after its read strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      h_q     <= '0;
      w_q     <= '0;
      g_q     <= '0;
      size_q  <= '0;
      chan_q  <= '0;
      grp_q   <= '0;
      pend_q  <= 1'b0;
      rng_q   <= 1'b0;
      tap_p_q <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      h_q     <= h_d;
      w_q     <= w_d;
      g_q     <= g_d;
      size_q  <= size_d;
      chan_q  <= chan_d;
      grp_q   <= grp_d;
      pend_q  <= state_q == FETCH;
      rng_q   <= tap_rng;
      tap_p_q <= t_q;
      if (pend_q)
        for (int l = 0; l < CHANNEL_PARALLELISM; l++)
          win_q[l][tap_p_q] <= (rng_q && lane_on[l])
            ? rd_data[DATA_WIDTH*l +: DATA_WIDTH]
            : '0;
    end
  end

  assign out_st  = state_q == OUT;
  assign rd_en   = (state_q == FETCH) && tap_rng;
  assign rd_addr = rd_en ? tap_addr : '0;
  assign busy    = state_q != IDLE;
  assign done    = state_q == FIN;

  assign win.win_valid       = out_st;
  assign win.channel_sel     = out_st ? 8'({g_q, 2'b00}) : '0;
  assign win.win_last_group  = out_st && last_g;
  assign win.win_last        = out_st && last_g
                            && last_w && last_h;
  assign win.window_feature1 = win_q[0];
  assign win.window_feature2 = win_q[1];
  assign win.window_feature3 = win_q[2];
  assign win.window_feature4 = win_q[3];

endmodule

// File: tb/tb_dw_window_feeder.sv
// tb_dw_window_feeder: directed passes with random buffer
// contents checked against a per-window reference model.
module tb_dw_window_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  input_size = 8'd0;
  logic [7:0]  channel = 8'd0;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [31:0] rd_data = '0;
  logic        busy, done;

  dw_window_feeder_if #(.DATA_WIDTH(8)) win_if ();

  dw_window_feeder #(
    .DATA_WIDTH(8),
    .KERNEL_SIZE(3),
    .CHANNEL_PARALLELISM(4),
    .ADDR_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .input_size(input_size),
    .channel(channel),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .win(win_if),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct packed {
    logic [3:0][71:0] f;
    logic [7:0]       sel;
    logic             lg;
    logic             last;
  } win_t;

  win_t        exp_q[$];
  logic [15:0] addr_q[$];
  win_t        first_win;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, want);
    end
  endtask

  function automatic win_t cur_win();
    win_t c;
    c.f[0] = win_if.window_feature1;
    c.f[1] = win_if.window_feature2;
    c.f[2] = win_if.window_feature3;
    c.f[3] = win_if.window_feature4;
    c.sel  = win_if.channel_sel;
    c.lg   = win_if.win_last_group;
    c.last = win_if.win_last;
    return c;
  endfunction

  task automatic fill_rand(input int n);
    for (int a = 0; a < n; a++) mem[16'(a)] = $urandom;
  endtask

  // pixel code: 0x80 + y*16 + x*4 + lane
  task automatic fill_codes(input int hh);
    logic [31:0] wd;
    for (int y = 0; y < hh; y++)
      for (int x = 0; x < hh; x++) begin
        for (int l = 0; l < 4; l++)
          wd[8*l +: 8] = 8'(128 + y*16 + x*4 + l);
        mem[16'(y*hh + x)] = wd;
      end
  endtask

  task automatic build_model(input int hh, input int cc);
    int gg, y, x, a;
    win_t e;
    logic [31:0] wd;
    gg = (cc + 3) / 4;
    exp_q.delete();
    addr_q.delete();
    for (int h = 0; h < hh; h++)
      for (int w = 0; w < hh; w++)
        for (int g = 0; g < gg; g++) begin
          e = '0;
          for (int t = 0; t < 9; t++) begin
            y = h + t / 3 - 1;
            x = w + t % 3 - 1;
            if (y >= 0 && y < hh && x >= 0 && x < hh) begin
              a = (y*hh + x)*gg + g;
              addr_q.push_back(16'(a));
              wd = mem[16'(a)];
              for (int l = 0; l < 4; l++)
                if (g*4 + l < cc)
                  e.f[l][8*t +: 8] = wd[8*l +: 8];
            end
          end
          e.sel  = 8'(g*4);
          e.lg   = g == gg - 1;
          e.last = h == hh-1 && w == hh-1 && g == gg-1;
          exp_q.push_back(e);
        end
  endtask

  task automatic run_pass(input int hh, input int cc,
                          input bit bp, input int bp_win,
                          input bit poke);
    int   cyc, wi, nwin, stall, last_rise;
    bit   seen_rd, seen_valid, in_stall, fin, prev_valid;
    win_t snap, c, e;
    build_model(hh, cc);
    nwin = exp_q.size();
    cyc = 0; wi = 0; stall = 0; last_rise = 0;
    seen_rd = 0; seen_valid = 0; in_stall = 0;
    fin = 0; prev_valid = 0;
    snap = '0;
    win_if.win_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    input_size = 8'(hh);
    channel = 8'(cc);
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        chk("busy_after_start", 128'(busy), 128'(1));
      end
      if (poke && cyc == 3) begin
        start = 1'b1;
        input_size = 8'd2;
        channel = 8'd8;
      end
      if (poke && cyc == 4) begin
        start = 1'b0;
        input_size = 8'(hh);
        channel = 8'(cc);
      end
      if (rd_en) begin
        if (!seen_rd) begin
          chk("first_rd_cycle", 128'(cyc), 128'(5));
          seen_rd = 1;
        end
        if (addr_q.size() == 0)
          chk("rd_unexpected", 128'(rd_en), 128'(0));
        else
          chk("rd_addr", 128'(rd_addr),
              128'(addr_q.pop_front()));
      end
      if (wi == nwin) begin
        chk("done_after_last", 128'(done), 128'(1));
        fin = 1;
      end else begin
        chk("no_early_done", 128'(done), 128'(0));
        if (in_stall) begin
          chk("bp_valid_held", 128'(win_if.win_valid),
              128'(1));
          chk("bp_data_held", 128'(cur_win()), 128'(snap));
          chk("bp_no_read", 128'(rd_en), 128'(0));
        end
        if (win_if.win_valid) begin
          c = cur_win();
          if (!seen_valid) begin
            chk("first_valid_cycle", 128'(cyc), 128'(11));
            seen_valid = 1;
          end else if (!bp && !prev_valid) begin
            chk("window_interval", 128'(cyc - last_rise),
                128'(11));
          end
          if (!prev_valid) last_rise = cyc;
          if (bp && wi == bp_win && stall < 5) begin
            if (stall == 0) snap = c;
            win_if.win_ready = 1'b0;
            in_stall = 1;
            stall++;
          end else begin
            win_if.win_ready = 1'b1;
            in_stall = 0;
            e = exp_q.pop_front();
            for (int l = 0; l < 4; l++)
              chk("win_lane", 128'(c.f[l]), 128'(e.f[l]));
            chk("channel_sel", 128'(c.sel), 128'(e.sel));
            chk("last_group", 128'(c.lg), 128'(e.lg));
            chk("win_last", 128'(c.last), 128'(e.last));
            if (wi == 0) first_win = c;
            wi++;
          end
        end
        prev_valid = win_if.win_valid;
      end
    end
    chk("pass_finished", 128'(fin), 128'(1));
    chk("window_count", 128'(wi), 128'(nwin));
    chk("addr_left", 128'(addr_q.size()), 128'(0));
    @(negedge clk);
    chk("done_one_cycle", 128'(done), 128'(0));
    chk("idle_after_pass", 128'(busy), 128'(0));
  endtask

  initial begin
    win_if.win_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 128'(rd_en), 128'(0));
    chk("rst_rd_addr", 128'(rd_addr), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_valid", 128'(win_if.win_valid), 128'(0));
    chk("rst_window", 128'(cur_win()), 128'(0));
    rst = 1'b0;

    fill_codes(3);
    run_pass(3, 4, 0, 0, 0);
    chk("w00_tap0_lane0", 128'(first_win.f[0][7:0]),
        128'(0));
    chk("w00_tap6_lane3", 128'(first_win.f[3][55:48]),
        128'(0));
    chk("w00_center_lane2", 128'(first_win.f[2][39:32]),
        128'(8'h82));
    chk("w00_tap8_lane0", 128'(first_win.f[0][71:64]),
        128'(8'h94));

    @(negedge clk);
    start = 1'b1;
    input_size = 8'd3;
    channel = 8'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    chk("abort_rd", 128'({rd_en, rd_addr}), 128'(0));
    chk("abort_busy_done", 128'({busy, done}), 128'(0));
    chk("abort_valid", 128'(win_if.win_valid), 128'(0));
    chk("abort_window", 128'(cur_win()), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", 128'({busy, done}), 128'(0));
    end
    run_pass(3, 4, 0, 0, 0);

    fill_rand(16);
    run_pass(4, 3, 0, 0, 1);

    fill_rand(8);
    run_pass(2, 8, 1, 3, 0);

    @(negedge clk);
    start = 1'b1;
    input_size = 8'd3;
    channel = 8'd0;
    @(negedge clk);
    chk("c0_done", 128'(done), 128'(1));
    chk("c0_valid", 128'(win_if.win_valid), 128'(0));
    channel = 8'd4;
    @(negedge clk);
    start = 1'b0;
    chk("c0_done_pulse", 128'(done), 128'(0));
    chk("c0_start_ignored", 128'(busy), 128'(0));
    @(negedge clk);
    chk("c0_still_idle", 128'({busy, win_if.win_valid}),
        128'(0));

    fill_rand(50);
    run_pass(5, 6, 1, 7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
